// File: rtl/digit_line_sequencer_if.sv
// digit_line_sequencer_if: pixel stream input and scan line-pair output bundle
interface digit_line_sequencer_if #(
    parameter int WIDTH = 180,
    parameter int ROW_W = 8
);
    logic             pix_valid;
    logic             pix_data;
    logic             pix_sof;
    logic             pix_eol;
    logic             pix_ready;
    logic             err_clr;
    logic             line_clk;
    logic [WIDTH-1:0] line1;
    logic [WIDTH-1:0] line2;
    logic [ROW_W-1:0] h;
    logic             frame_done;
    logic             err_short;
    logic             err_long;
    logic             err_sync;

    modport master (
        output pix_valid, pix_data, pix_sof, pix_eol, err_clr,
        input  pix_ready, line_clk, line1, line2, h, frame_done, err_short, err_long, err_sync
    );

    modport slave (
        input  pix_valid, pix_data, pix_sof, pix_eol, err_clr,
        output pix_ready, line_clk, line1, line2, h, frame_done, err_short, err_long, err_sync
    );
endinterface

// File: rtl/digit_line_sequencer.sv
// digit_line_sequencer: assembles pixel rows and presents each as a held line pair for the scan engine
module digit_line_sequencer #(
    parameter int WIDTH       = 180,
    parameter int HEIGHT      = 240,
    parameter int ROW_W       = 8,
    parameter int SCAN_CYCLES = 182
) (
    input logic                   video_clk,
    input logic                   rst,
    digit_line_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = $clog2(WIDTH);
    localparam int NW = $clog2(SCAN_CYCLES + 1);
    localparam logic [CW-1:0]    LAST_COL = CW'(WIDTH - 1);
    localparam logic [IW-1:0]    LAST_IDX = IW'(WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
    localparam logic [NW-1:0]    SCAN_END = NW'(SCAN_CYCLES);

    typedef enum logic [1:0] {IDLE, FILL, DISCARD, PRESENT} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    col, col_n;
    logic [ROW_W-1:0] row, row_n;
    logic [ROW_W-1:0] h, h_n;
    logic [NW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] rowbuf, rowbuf_n;
    logic [WIDTH-1:0] line1, line1_n;
    logic [WIDTH-1:0] line2, line2_n;
    logic             ready, ready_n;
    logic             line_clk, line_clk_n;
    logic             frame_done, frame_done_n;
    logic             err_short, err_short_n;
    logic             err_long, err_long_n;
    logic             err_sync, err_sync_n;
    logic             acc, wr, done;
    logic             set_short, set_long, set_sync;
    logic [IW-1:0]    wi;

    assign acc            = bus.pix_valid && ready;
    assign bus.pix_ready  = ready;
    assign bus.line_clk   = line_clk;
    assign bus.line1      = line1;
    assign bus.line2      = line2;
    assign bus.h          = h;
    assign bus.frame_done = frame_done;
    assign bus.err_short  = err_short;
    assign bus.err_long   = err_long;
    assign bus.err_sync   = err_sync;

    // Next state: pixel capture, row completion, line presentation, scan window and sticky errors
    always_comb begin
        state_n      = state;
        col_n        = col;
        row_n        = row;
        h_n          = h;
        cnt_n        = cnt;
        rowbuf_n     = rowbuf;
        line1_n      = line1;
        line2_n      = line2;
        line_clk_n   = 1'b0;
        frame_done_n = 1'b0;
        wr           = 1'b0;
        done         = 1'b0;
        set_short    = 1'b0;
        set_long     = 1'b0;
        set_sync     = 1'b0;
        wi           = col[IW-1:0];
        case (state)
            IDLE: begin
                if (acc && bus.pix_sof) begin
                    wr      = 1'b1;
                    wi      = '0;
                    col_n   = CW'(1);
                    row_n   = '0;
                    state_n = FILL;
                end
            end
            FILL, DISCARD: begin
                if (acc && bus.pix_sof && (row != '0 || col != '0)) begin
                    set_sync = 1'b1;
                    wr       = 1'b1;
                    wi       = '0;
                    col_n    = CW'(1);
                    row_n    = '0;
                    state_n  = FILL;
                end else if (acc && state == FILL) begin
                    wr      = 1'b1;
                    col_n   = col + 1'b1;
                    state_n = (col == LAST_COL && !bus.pix_eol) ? DISCARD : FILL;
                end else if (acc) begin
                    set_long = 1'b1;
                    done     = bus.pix_eol;
                end
            end
            PRESENT: begin
                cnt_n = cnt + 1'b1;
                if (cnt == SCAN_END) begin
                    col_n        = '0;
                    frame_done_n = (row == LAST_ROW);
                    row_n        = (row == LAST_ROW) ? '0 : row + 1'b1;
                    state_n      = (row == LAST_ROW) ? IDLE : FILL;
                end
            end
            default: state_n = IDLE;
        endcase
        if (wr) begin
            rowbuf_n[wi] = bus.pix_data;
            done         = bus.pix_eol;
            if (bus.pix_eol && wi != LAST_IDX) begin
                set_short = 1'b1;
                for (int k = 0; k < WIDTH; k++) begin
                    if (k > int'(wi)) rowbuf_n[k] = 1'b1;
                end
            end
        end
        if (done) begin
            state_n    = PRESENT;
            cnt_n      = NW'(1);
            line_clk_n = 1'b1;
            line2_n    = (row_n == '0) ? '1 : line1;
            line1_n    = rowbuf_n;
            h_n        = row_n;
            rowbuf_n   = '1;
        end
        ready_n     = (state_n != PRESENT);
        err_short_n = set_short || (err_short && !bus.err_clr);
        err_long_n  = set_long || (err_long && !bus.err_clr);
        err_sync_n  = set_sync || (err_sync && !bus.err_clr);
    end

    // State and output registers; reset discards any partial row or window
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            h          <= '0;
            cnt        <= '0;
            rowbuf     <= '1;
            line1      <= '1;
            line2      <= '1;
            ready      <= 1'b0;
            line_clk   <= 1'b0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            err_sync   <= 1'b0;
        end else begin
            state      <= state_n;
            col        <= col_n;
            row        <= row_n;
            h          <= h_n;
            cnt        <= cnt_n;
            rowbuf     <= rowbuf_n;
            line1      <= line1_n;
            line2      <= line2_n;
            ready      <= ready_n;
            line_clk   <= line_clk_n;
            frame_done <= frame_done_n;
            err_short  <= err_short_n;
            err_long   <= err_long_n;
            err_sync   <= err_sync_n;
        end
    end
endmodule

// File: tb/tb_digit_line_sequencer.sv
// tb_digit_line_sequencer: row-level reference model checks of the line sequencer
module tb_digit_line_sequencer;
    localparam int WIDTH  = 8;
    localparam int HEIGHT = 3;
    localparam int SCAN   = 10;

    typedef struct {
        logic [WIDTH-1:0] l1;
        logic [WIDTH-1:0] l2;
        logic [7:0]       h;
        int               cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int low_run = 0;
    ev_t ev_q[$];
    int fd_q[$];
    int runs_q[$];
    int m_row = 0;
    logic [WIDTH-1:0] m_prev = '1;

    digit_line_sequencer_if #(.WIDTH(WIDTH), .ROW_W(8)) ifc ();

    digit_line_sequencer #(
        .WIDTH(WIDTH),
        .HEIGHT(HEIGHT),
        .ROW_W(8),
        .SCAN_CYCLES(SCAN)
    ) dut (
        .video_clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifc.line_clk === 1'b1) ev_q.push_back('{ifc.line1, ifc.line2, ifc.h, cyc});
        if (ifc.frame_done === 1'b1) fd_q.push_back(cyc);
        if (rst) low_run = 0;
        else if (ifc.pix_ready !== 1'b1) low_run++;
        else begin
            if (low_run > 0) runs_q.push_back(low_run);
            low_run = 0;
        end
    end

    function automatic void model_step(input logic [15:0] bits, input int n,
                                       output logic [WIDTH-1:0] el, output logic [WIDTH-1:0] e2,
                                       output logic [7:0] eh);
        for (int k = 0; k < WIDTH; k++) el[k] = (k < n) ? bits[k] : 1'b1;
        e2 = (m_row == 0) ? '1 : m_prev;
        eh = 8'(m_row);
        m_prev = el;
        m_row = (m_row + 1) % HEIGHT;
    endfunction

    task automatic idle();
        @(negedge clk);
        ifc.pix_valid = 1'b0;
        ifc.pix_sof = 1'b0;
        ifc.pix_eol = 1'b0;
    endtask

    task automatic send_px(input logic d, input logic s, input logic e);
        int n = 0;
        @(negedge clk);
        ifc.pix_valid = 1'b1;
        ifc.pix_data = d;
        ifc.pix_sof = s;
        ifc.pix_eol = e;
        while (ifc.pix_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_px pix_ready=%b for 200 cycles, required 1", ifc.pix_ready);
        end
        @(posedge clk);
    endtask

    task automatic send_row(input logic [15:0] bits, input int n, input bit sof, input bit keep);
        for (int k = 0; k < n; k++) send_px(bits[k], sof && k == 0, k == n - 1);
        if (!keep) idle();
    endtask

    task automatic get_ev(output ev_t ev, output bit got);
        int t = 0;
        while (ev_q.size() == 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        got = (ev_q.size() != 0);
        if (got) ev = ev_q.pop_front();
    endtask

    task automatic do_reset();
        ifc.pix_valid = 1'b0;
        ifc.pix_sof = 1'b0;
        ifc.pix_eol = 1'b0;
        ifc.pix_data = 1'b0;
        ifc.err_clr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        ev_q.delete();
        fd_q.delete();
        runs_q.delete();
        m_row = 0;
        m_prev = '1;
    endtask

    task automatic test_reset();
        ifc.pix_valid = 1'b0;
        ifc.pix_sof = 1'b0;
        ifc.pix_eol = 1'b0;
        ifc.pix_data = 1'b0;
        ifc.err_clr = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ifc.line1 !== 8'hFF || ifc.line2 !== 8'hFF || ifc.h !== 8'd0) begin
            failures++;
            $display("FAIL reset_lines line1=%h line2=%h h=%0d required FF FF 0", ifc.line1, ifc.line2, ifc.h);
        end
        checks++;
        if (ifc.line_clk !== 1'b0 || ifc.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses line_clk=%b frame_done=%b required 0 0", ifc.line_clk, ifc.frame_done);
        end
        checks++;
        if (ifc.pix_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready pix_ready=%b required 0", ifc.pix_ready);
        end
        checks++;
        if ({ifc.err_short, ifc.err_long, ifc.err_sync} !== 3'b000) begin
            failures++;
            $display("FAIL reset_errs errs=%b required 000", {ifc.err_short, ifc.err_long, ifc.err_sync});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame();
        logic [15:0] b[3] = '{16'h00F0, 16'h000F, 16'h00AA};
        logic [WIDTH-1:0] el, e2;
        logic [7:0] eh;
        ev_t ev;
        bit got;
        int last = 0;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            send_row(b[r], 8, r == 0, 1'b0);
            model_step(b[r], 8, el, e2, eh);
            get_ev(ev, got);
            checks++;
            if (!got || ev.l1 !== el || ev.l2 !== e2 || ev.h !== eh) begin
                failures++;
                $display("FAIL frame_row%0d got=%0d line1=%h line2=%h h=%0d required line1=%h line2=%h h=%0d",
                         r, got, ev.l1, ev.l2, ev.h, el, e2, eh);
            end
            last = ev.cyc;
        end
        repeat (15) @(negedge clk);
        checks++;
        if (fd_q.size() != 1 || fd_q[0] - last != SCAN) begin
            failures++;
            $display("FAIL frame_done count=%0d delay=%0d required count=1 delay=%0d",
                     fd_q.size(), fd_q.size() > 0 ? fd_q[0] - last : -1, SCAN);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] b[3];
        logic [WIDTH-1:0] el, e2;
        logic [7:0] eh;
        ev_t ev;
        bit got;
        do_reset();
        for (int r = 0; r < 3; r++) b[r] = 16'($urandom_range(0, 255));
        for (int r = 0; r < 3; r++) send_row(b[r], 8, r == 0, 1'b1);
        idle();
        for (int r = 0; r < 3; r++) begin
            model_step(b[r], 8, el, e2, eh);
            get_ev(ev, got);
            checks++;
            if (!got || ev.l1 !== el || ev.l2 !== e2 || ev.h !== eh) begin
                failures++;
                $display("FAIL b2b_row%0d got=%0d line1=%h line2=%h h=%0d required line1=%h line2=%h h=%0d",
                         r, got, ev.l1, ev.l2, ev.h, el, e2, eh);
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (runs_q.size() != 3) begin
            failures++;
            $display("FAIL b2b_windows count=%0d required 3", runs_q.size());
        end
        foreach (runs_q[i]) begin
            checks++;
            if (runs_q[i] != SCAN) begin
                failures++;
                $display("FAIL b2b_ready_low%0d cycles=%0d required %0d", i, runs_q[i], SCAN);
            end
        end
    endtask

    task automatic test_short();
        logic [WIDTH-1:0] el, e2;
        logic [7:0] eh;
        ev_t ev;
        bit got;
        do_reset();
        send_row(16'h0000, 5, 1'b1, 1'b0);
        model_step(16'h0000, 5, el, e2, eh);
        get_ev(ev, got);
        checks++;
        if (!got || ev.l1 !== el || ev.l2 !== e2 || ev.h !== eh) begin
            failures++;
            $display("FAIL short_line got=%0d line1=%h line2=%h h=%0d required line1=%h line2=%h h=%0d",
                     got, ev.l1, ev.l2, ev.h, el, e2, eh);
        end
        checks++;
        if ({ifc.err_short, ifc.err_long, ifc.err_sync} !== 3'b100) begin
            failures++;
            $display("FAIL short_flag errs=%b required 100", {ifc.err_short, ifc.err_long, ifc.err_sync});
        end
        @(negedge clk);
        ifc.err_clr = 1'b1;
        @(negedge clk);
        ifc.err_clr = 1'b0;
        checks++;
        if (ifc.err_short !== 1'b0) begin
            failures++;
            $display("FAIL short_clear err_short=%b required 0", ifc.err_short);
        end
    endtask

    task automatic test_long();
        logic [15:0] b;
        logic [WIDTH-1:0] el, e2;
        logic [7:0] eh;
        ev_t ev;
        bit got;
        do_reset();
        b = {5'($urandom_range(0, 31)), 3'b000, 8'h3C};
        for (int k = 0; k < 10; k++) send_px(b[k], k == 0, 1'b0);
        idle();
        repeat (3) @(negedge clk);
        checks++;
        if (ev_q.size() != 0) begin
            failures++;
            $display("FAIL long_early line_clk_count=%0d required 0", ev_q.size());
        end
        send_px(b[10], 1'b0, 1'b1);
        idle();
        model_step(b, 11, el, e2, eh);
        get_ev(ev, got);
        checks++;
        if (!got || ev.l1 !== el || ev.l2 !== e2 || ev.h !== eh) begin
            failures++;
            $display("FAIL long_line got=%0d line1=%h line2=%h h=%0d required line1=%h line2=%h h=%0d",
                     got, ev.l1, ev.l2, ev.h, el, e2, eh);
        end
        checks++;
        if ({ifc.err_short, ifc.err_long, ifc.err_sync} !== 3'b010) begin
            failures++;
            $display("FAIL long_flag errs=%b required 010", {ifc.err_short, ifc.err_long, ifc.err_sync});
        end
    endtask

    task automatic test_sync();
        logic [15:0] b0, b1, b2;
        logic [WIDTH-1:0] el, e2;
        logic [7:0] eh;
        ev_t ev;
        bit got;
        do_reset();
        b0 = 16'($urandom_range(0, 255));
        b1 = 16'($urandom_range(0, 255));
        b2 = 16'($urandom_range(0, 255));
        send_row(b0, 8, 1'b1, 1'b0);
        model_step(b0, 8, el, e2, eh);
        get_ev(ev, got);
        checks++;
        if (!got || ev.l1 !== el || ev.h !== eh) begin
            failures++;
            $display("FAIL sync_row0 got=%0d line1=%h h=%0d required line1=%h h=%0d", got, ev.l1, ev.h, el, eh);
        end
        for (int k = 0; k < 3; k++) send_px(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        send_row(b1, 8, 1'b1, 1'b0);
        m_row = 0;
        model_step(b1, 8, el, e2, eh);
        get_ev(ev, got);
        checks++;
        if (!got || ev.l1 !== el || ev.l2 !== e2 || ev.h !== eh) begin
            failures++;
            $display("FAIL sync_restart got=%0d line1=%h line2=%h h=%0d required line1=%h line2=%h h=%0d",
                     got, ev.l1, ev.l2, ev.h, el, e2, eh);
        end
        checks++;
        if ({ifc.err_short, ifc.err_long, ifc.err_sync} !== 3'b001) begin
            failures++;
            $display("FAIL sync_flag errs=%b required 001", {ifc.err_short, ifc.err_long, ifc.err_sync});
        end
        send_row(b2, 8, 1'b0, 1'b0);
        model_step(b2, 8, el, e2, eh);
        get_ev(ev, got);
        checks++;
        if (!got || ev.l1 !== el || ev.l2 !== e2 || ev.h !== eh) begin
            failures++;
            $display("FAIL sync_next got=%0d line1=%h line2=%h h=%0d required line1=%h line2=%h h=%0d",
                     got, ev.l1, ev.l2, ev.h, el, e2, eh);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] b;
        logic [WIDTH-1:0] el, e2;
        logic [7:0] eh;
        ev_t ev;
        bit got;
        do_reset();
        send_row(16'h005A, 8, 1'b1, 1'b0);
        model_step(16'h005A, 8, el, e2, eh);
        get_ev(ev, got);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ifc.line1 !== 8'hFF || ifc.line2 !== 8'hFF || ifc.h !== 8'd0 || ifc.pix_ready !== 1'b0 ||
            ifc.line_clk !== 1'b0 || ifc.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs line1=%h line2=%h h=%0d ready=%b line_clk=%b frame_done=%b required FF FF 0 0 0 0",
                     ifc.line1, ifc.line2, ifc.h, ifc.pix_ready, ifc.line_clk, ifc.frame_done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        ev_q.delete();
        m_row = 0;
        m_prev = '1;
        send_row(16'($urandom_range(0, 255)), 8, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        checks++;
        if (ev_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_nosof line_clk_count=%0d required 0", ev_q.size());
        end
        b = 16'($urandom_range(0, 255));
        send_row(b, 8, 1'b1, 1'b0);
        model_step(b, 8, el, e2, eh);
        get_ev(ev, got);
        checks++;
        if (!got || ev.l1 !== el || ev.l2 !== e2 || ev.h !== eh) begin
            failures++;
            $display("FAIL midreset_resume got=%0d line1=%h line2=%h h=%0d required line1=%h line2=%h h=%0d",
                     got, ev.l1, ev.l2, ev.h, el, e2, eh);
        end
    endtask

    task automatic test_random();
        logic [15:0] b;
        logic [WIDTH-1:0] el, e2;
        logic [7:0] eh;
        ev_t ev;
        bit got;
        bit es, elg;
        int n, t;
        do_reset();
        es = 1'b0;
        elg = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < HEIGHT; r++) begin
                n = $urandom_range(1, 11);
                b = 16'($urandom);
                send_row(b, n, r == 0, 1'b0);
                es = es || (n < WIDTH);
                elg = elg || (n > WIDTH);
                model_step(b, n, el, e2, eh);
                get_ev(ev, got);
                checks++;
                if (!got || ev.l1 !== el || ev.l2 !== e2 || ev.h !== eh) begin
                    failures++;
                    $display("FAIL rand_f%0d_r%0d n=%0d got=%0d line1=%h line2=%h h=%0d required line1=%h line2=%h h=%0d",
                             f, r, n, got, ev.l1, ev.l2, ev.h, el, e2, eh);
                end
                checks++;
                if ({ifc.err_short, ifc.err_long, ifc.err_sync} !== {es, elg, 1'b0}) begin
                    failures++;
                    $display("FAIL rand_errs_f%0d_r%0d errs=%b required %b", f, r,
                             {ifc.err_short, ifc.err_long, ifc.err_sync}, {es, elg, 1'b0});
                end
                if ($urandom_range(0, 1) == 1) begin
                    @(negedge clk);
                    ifc.err_clr = 1'b1;
                    @(negedge clk);
                    ifc.err_clr = 1'b0;
                    es = 1'b0;
                    elg = 1'b0;
                end
            end
            t = 0;
            while (fd_q.size() == 0 && t < 30) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (fd_q.size() != 1) begin
                failures++;
                $display("FAIL rand_frame_done_f%0d count=%0d required 1", f, fd_q.size());
            end
            fd_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_short();
        test_long();
        test_sync();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/digit_line_sequencer.md
Name: digit_line_sequencer

Overview:
- Front-end controller for the digit-recognition scan datapath.
- Collects the binarized pixel stream row by row into a row buffer.
- Presents each completed row as a stable line pair to the scan engine: line1 is the current row, line2 is the previous row. It also presents the row index h and a one-cycle line_clk start pulse.
- Holds the presented line for a fixed scan window, applies backpressure upstream during that window, and flags end-of-frame and stream errors.

Parameters:
WIDTH, 180, pixels per row (width of line1/line2)
HEIGHT, 240, rows per frame
ROW_W, 8, width of row index h
SCAN_CYCLES, 182, cycles line1/line2/h are held after line_clk; must be >= WIDTH+2

Ports:
video_clk  input  1  single clock for all logic
rst  input  1  asynchronous, active-high reset
pix_valid  input  1  pixel qualifier
pix_data  input  1  binarized pixel, 0=black 1=white
pix_sof  input  1  marks first pixel of frame; qualified by pix_valid
pix_eol  input  1  marks last pixel of row; qualified by pix_valid
pix_ready  output  1  pixel accepted when pix_valid && pix_ready
err_clr  input  1  clears sticky error flags
line_clk  output  1  one-cycle pulse: new line1/line2/h valid
line1  output  WIDTH  current row, bit k = column k
line2  output  WIDTH  previous row; all ones for row 0
h  output  ROW_W  row index of line1, 0..HEIGHT-1
frame_done  output  1  one-cycle pulse after scan window of row HEIGHT-1 ends
err_short  output  1  sticky: row ended by pix_eol before WIDTH pixels
err_long  output  1  sticky: pixels arrived past WIDTH before pix_eol
err_sync  output  1  sticky: pix_sof accepted mid-frame

Behaviour:
- Reset values:
  - line1 and line2 all ones; h=0.
  - line_clk, frame_done, pix_ready and all err flags 0.
  - State IDLE; col=0; row=0.
- State IDLE:
  - pix_ready=1; accepted pixels without pix_sof are dropped.
  - An accepted pix_sof pixel is stored at column 0 with col=1, row=0, and the state goes to FILL.
  - If that same pixel also has pix_eol, the row completes immediately, following the short-row rule.
- State FILL:
  - pix_ready=1; each accepted pixel is written to rowbuf[col] and col increments.
  - Row completes on an accepted pixel with col==WIDTH-1, or on an accepted pixel with pix_eol, whichever comes first.
  - Early pix_eol (col<WIDTH-1): unwritten columns are forced to 1 (white) and err_short is set.
  - Completion at col==WIDTH-1 without pix_eol goes to DISCARD; otherwise it goes to PRESENT.
  - Accepted pix_sof while in FILL, when not at row 0 col 0:
    - set err_sync, set row=0;
    - store the pixel at column 0 and set col=1;
    - line outputs are untouched.
- State DISCARD:
  - pix_ready=1; pixels are dropped and err_long is set on the first dropped pixel.
  - An accepted pix_eol goes to PRESENT.
  - An accepted pix_sof behaves as in FILL (including err_sync) and returns to FILL.
- State PRESENT:
  - Entered on the cycle after row completion.
  - On entry, in the same cycle:
    - line2<=line1, or all ones if row==0;
    - line1<=rowbuf, h<=row, line_clk=1 for exactly one cycle;
    - rowbuf is reset to all ones.
  - pix_ready=0 for the whole window.
  - A counter runs SCAN_CYCLES cycles, counting the line_clk cycle as 1.
  - At the end of the window:
    - if row==HEIGHT-1: frame_done pulses for one cycle, row=0, go to IDLE;
    - otherwise: row++, col=0, go to FILL.
- Stability: line1, line2 and h change only in the line_clk cycle.
- err_clr clears all err flags in the next cycle. A set event in the same cycle wins over err_clr.
- Counters: col has width clog2(WIDTH)+1 and row is ROW_W bits; neither wraps within a frame.
- Reset asserted mid-row or mid-window: everything returns to reset values asynchronously, and the partial row is lost.

Test Plan:
1. WIDTH=8, HEIGHT=3, SCAN_CYCLES=10; stream 3 rows of 8 pixels (row0=8'hF0, row1=8'h0F, row2=8'hAA) with pix_eol on the 8th pixel.
   - line_clk pulses 3 times with h=0,1,2.
   - line1/line2 read F0/FF, then 0F/F0, then AA/0F.
   - frame_done pulses exactly once, 10 cycles after the third line_clk.
2. Hold pix_valid=1 continuously.
   - pix_ready=0 for exactly 10 cycles starting at each line_clk.
   - No pixel is lost, and the next row starts at column 0.
3. Assert pix_eol on the 5th pixel with data 0,0,0,0,0.
   - line1=8'hE0 and err_short=1.
   - err_clr clears it the next cycle.
4. Send 11 pixels before pix_eol (first 8 = 8'h3C).
   - line1=8'h3C and err_long=1.
   - line_clk fires only after the pix_eol pixel.
5. pix_sof on row 1, column 3.
   - err_sync=1 and the row counter restarts.
   - The next line_clk has h=0 and line2=all ones.
6. Assert rst during a scan window.
   - All outputs return to reset values.
   - Pixels without pix_sof are ignored until the next pix_sof.
